hack_screen_scanout: RTL and testbench

//  Pixel source for the RGB LCD path: consumes timing (de/hs/vs, h_pos/v_pos) from the LCD timing generator.

---
 rtl/hack_screen_pkg.sv | 12 +
 rtl/sync_delay.sv | 25 ++
 rtl/hack_screen_scanout.sv | 133 +++++++++++++
 tb/tb_hack_screen_scanout.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_screen_pkg.sv
// Shared geometry and types for the Hack screen scan-out path.
package hack_screen_pkg;

  localparam int unsigned SCREEN_W      = 512;
  localparam int unsigned SCREEN_H      = 256;
  localparam int unsigned WORDS_PER_ROW = 32;
  localparam logic [15:0] SCREEN_BASE   = 16'h4000;

  typedef logic [15:0] rgb565_t;
  typedef logic [12:0] scr_addr_t;

endpackage

// File: rtl/sync_delay.sv
// Reset-cleared shift register, Width bits wide and Depth stages deep.
module sync_delay #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] stage_q [Depth];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(Depth); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < int'(Depth); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[Depth-1];

endmodule

// File: rtl/hack_screen_scanout.sv
// Hack 512x256 mono screen scan-out to RGB565 with 2-clk aligned syncs.
// Optional window border ring enabled by defining SCREEN_BORDER_EN.
module hack_screen_scanout
  import hack_screen_pkg::*;
#(
  parameter int unsigned X0         = 144,
  parameter int unsigned Y0         = 112,
  parameter rgb565_t     FG_RGB     = 16'h0000,
  parameter rgb565_t     BG_RGB     = 16'hFFFF,
  parameter rgb565_t     BORDER_RGB = 16'hF800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        de_i,
  input  logic        hs_i,
  input  logic        vs_i,
  input  logic [9:0]  h_pos,
  input  logic [9:0]  v_pos,
  output scr_addr_t   scr_addr,
  output logic        scr_rd_en,
  input  logic [15:0] scr_rdata,
  output rgb565_t     rgb,
  output logic        de_o,
  output logic        hs_o,
  output logic        vs_o,
  output logic        frame_done
);

  localparam logic [9:0] XLo  = 10'(X0);
  localparam logic [9:0] XHi  = 10'(X0 + SCREEN_W);
  localparam logic [9:0] YLo  = 10'(Y0);
  localparam logic [9:0] YHi  = 10'(Y0 + SCREEN_H);
  localparam logic [8:0] XOff = 9'(X0);
  localparam logic [7:0] YOff = 8'(Y0);

  logic       in_win, border_hit, last_pix, pix_bit;
  logic [8:0] dx;
  logic [7:0] dy;
  logic [2:0] sync_s1, sync_s2;

  // Stage 0: window decode and RAM request; combinational outputs are forced low in reset.
  always_comb begin
    in_win    = de_i && (h_pos >= XLo) && (h_pos < XHi) && (v_pos >= YLo) && (v_pos < YHi);
    dx        = h_pos[8:0] - XOff;
    dy        = v_pos[7:0] - YOff;
    last_pix  = in_win && (dx == 9'h1FF) && (dy == 8'hFF);
    scr_rd_en = reset && in_win && (dx[3:0] == 4'd0);
    scr_addr  = (reset && in_win) ? {dy, dx[8:4]} : '0;
  end

`ifdef SCREEN_BORDER_EN
  localparam logic [9:0] XBl = 10'(X0 - 1);
  localparam logic [9:0] YBl = 10'(Y0 - 1);

  assign border_hit = de_i && (h_pos >= XBl) && (h_pos <= XHi) &&
                      (v_pos >= YBl) && (v_pos <= YHi) &&
                      ((h_pos == XBl) || (h_pos == XHi) || (v_pos == YBl) || (v_pos == YHi));
`else
  assign border_hit = 1'b0;
`endif

  // Stage 1 state.
  logic        win_q, border_q, last_q;
  logic [3:0]  idx_q;
  logic [15:0] word_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q    <= 1'b0;
      border_q <= 1'b0;
      last_q   <= 1'b0;
      idx_q    <= 4'd0;
      word_q   <= 16'h0000;
    end else begin
      win_q    <= in_win;
      border_q <= border_hit;
      last_q   <= last_pix;
      idx_q    <= dx[3:0];
      if (win_q && (idx_q == 4'd0)) word_q <= scr_rdata;
    end
  end

  // The first pixel of a word comes straight off the RAM bus; the rest from the held copy.
  assign pix_bit = (idx_q == 4'd0) ? scr_rdata[0] : word_q[idx_q];

  sync_delay #(
    .Width(3),
    .Depth(1)
  ) u_sync_s1 (
    .clk  (clk),
    .reset(reset),
    .d    ({de_i, hs_i, vs_i}),
    .q    (sync_s1)
  );

  // Stage 2 state.
  rgb565_t rgb_q, rgb_d;
  logic    frame_done_q;

  always_comb begin
    rgb_d = '0;
    if (win_q)         rgb_d = pix_bit ? FG_RGB : BG_RGB;
    else if (border_q) rgb_d = BORDER_RGB;
    else if (sync_s1[2]) rgb_d = BG_RGB;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      rgb_q        <= rgb_d;
      frame_done_q <= last_q;
    end
  end

  sync_delay #(
    .Width(3),
    .Depth(1)
  ) u_sync_s2 (
    .clk  (clk),
    .reset(reset),
    .d    (sync_s1),
    .q    (sync_s2)
  );

  assign rgb        = rgb_q;
  assign frame_done = frame_done_q;
  assign de_o       = sync_s2[2];
  assign hs_o       = sync_s2[1];
  assign vs_o       = sync_s2[0];

endmodule

// File: tb/tb_hack_screen_scanout.sv
// Directed bench for hack_screen_scanout with a 1-clk-latency screen RAM model.
module tb_hack_screen_scanout;

  localparam logic [15:0] Fg = 16'h0000;
  localparam logic [15:0] Bg = 16'hFFFF;
`ifdef SCREEN_BORDER_EN
  localparam logic [15:0] Ring = 16'hF800;
`else
  localparam logic [15:0] Ring = 16'hFFFF;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        de_i, hs_i, vs_i;
  logic [9:0]  h_pos, v_pos;
  logic [12:0] scr_addr;
  logic        scr_rd_en;
  logic [15:0] scr_rdata;
  logic [15:0] rgb;
  logic        de_o, hs_o, vs_o, frame_done;

  logic [15:0] mem [8192];
  int checks = 0;
  int errors = 0;

  hack_screen_scanout dut (
    .clk       (clk),
    .reset     (reset),
    .de_i      (de_i),
    .hs_i      (hs_i),
    .vs_i      (vs_i),
    .h_pos     (h_pos),
    .v_pos     (v_pos),
    .scr_addr  (scr_addr),
    .scr_rd_en (scr_rd_en),
    .scr_rdata (scr_rdata),
    .rgb       (rgb),
    .de_o      (de_o),
    .hs_o      (hs_o),
    .vs_o      (vs_o),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (scr_rd_en) scr_rdata <= mem[scr_addr];

  // Inputs change on the falling edge; outputs then reflect the pixel driven two calls earlier.
  task automatic drive(input int h, input int v, input logic de, input logic hs, input logic vs);
    @(negedge clk);
    h_pos = 10'(h);
    v_pos = 10'(v);
    de_i  = de;
    hs_i  = hs;
    vs_i  = vs;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    drive(144, 112, 1'b1, 1'b1, 1'b1);
    #1;
    checks++; if (rgb !== 16'h0) begin errors++; $display("FAIL reset_rgb got %h want 0000", rgb); end
    checks++; if (de_o !== 1'b0) begin errors++; $display("FAIL reset_de_o got %b want 0", de_o); end
    checks++; if (hs_o !== 1'b0) begin errors++; $display("FAIL reset_hs_o got %b want 0", hs_o); end
    checks++; if (vs_o !== 1'b0) begin errors++; $display("FAIL reset_vs_o got %b want 0", vs_o); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    checks++; if (scr_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", scr_rd_en); end
    checks++; if (scr_addr !== 13'h0) begin errors++; $display("FAIL reset_addr got %h want 0000", scr_addr); end
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_single_word;
    mem[0] = 16'h0001;
    drive(144, 112, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (scr_rd_en !== 1'b1) begin errors++; $display("FAIL single_rd_en got %b want 1", scr_rd_en); end
    checks++; if (scr_addr !== 13'h0) begin errors++; $display("FAIL single_addr got %h want 0000", scr_addr); end
    drive(145, 112, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (scr_rd_en !== 1'b0) begin errors++; $display("FAIL single_rd_en2 got %b want 0", scr_rd_en); end
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (rgb !== Fg) begin errors++; $display("FAIL single_fg got %h want %h", rgb, Fg); end
    checks++; if (de_o !== 1'b1) begin errors++; $display("FAIL single_de_o got %b want 1", de_o); end
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (rgb !== Bg) begin errors++; $display("FAIL single_bg got %h want %h", rgb, Bg); end
    drive(0, 0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (rgb !== 16'h0) begin errors++; $display("FAIL single_idle got %h want 0000", rgb); end
  endtask

  task automatic test_row;
    int reads = 0;
    int j;
    logic [15:0] exp_rgb;
    for (int a = 32; a < 64; a++) mem[a] = 16'hAAAA;
    for (int i = 0; i < 802; i++) begin
      if (i < 800) drive(i, 113, 1'b1, 1'b0, 1'b0);
      else drive(0, 0, 1'b0, 1'b0, 1'b0);
      #1;
      if (scr_rd_en) reads++;
      if (i == 144) begin
        checks++;
        if (scr_addr !== 13'd32) begin errors++; $display("FAIL row_first_addr got %0d want 32", scr_addr); end
      end
      if (i >= 2) begin
        j = i - 2;
        if (j >= 144 && j < 656) exp_rgb = ((j - 144) % 2 == 1) ? Fg : Bg;
        else if (j == 143 || j == 656) exp_rgb = Ring;
        else exp_rgb = Bg;
        checks++;
        if (rgb !== exp_rgb) begin
          errors++; $display("FAIL row_pixel h=%0d got %h want %h", j, rgb, exp_rgb);
        end
      end
    end
    checks++; if (reads != 32) begin errors++; $display("FAIL row_reads got %0d want 32", reads); end
  endtask

  task automatic test_outside;
    int          h_s [6] = '{143, 656, 300, 300, 0, 0};
    int          v_s [6] = '{200, 200, 50, 200, 0, 0};
    logic [15:0] e_s [4];
    logic [5:0]  de_s = 6'b000011;
    logic [5:0]  hs_s = 6'b000110;
    logic [5:0]  vs_s = 6'b001101;
    e_s = '{Ring, Ring, 16'h0, 16'h0};
    for (int i = 0; i < 6; i++) begin
      drive(h_s[i], v_s[i], de_s[i], hs_s[i], vs_s[i]);
      #1;
      checks++;
      if (scr_rd_en !== 1'b0) begin errors++; $display("FAIL outside_rd_en i=%0d got %b want 0", i, scr_rd_en); end
      if (i >= 2) begin
        checks++;
        if (rgb !== e_s[i-2]) begin errors++; $display("FAIL outside_rgb i=%0d got %h want %h", i-2, rgb, e_s[i-2]); end
        checks++;
        if ({de_o, hs_o, vs_o} !== {de_s[i-2], hs_s[i-2], vs_s[i-2]}) begin
          errors++;
          $display("FAIL outside_syncs i=%0d got %b%b%b want %b%b%b", i-2, de_o, hs_o, vs_o,
                   de_s[i-2], hs_s[i-2], vs_s[i-2]);
        end
      end
    end
  endtask

  // Sparse frame: only the 16-pixel read points plus the final window pixel are visited.
  task automatic test_frame;
    int reads = 0;
    int pulses = 0;
    int pulse_at = -1;
    int fin_idx = -1;
    int cnt = 0;
    int h;
    logic [12:0] last_addr = '0;
    for (int r = 110; r < 372; r++) begin
      for (int k = 0; k < 33; k++) begin
        h = -1;
        if (r >= 370) begin
          if (k == 0) h = 0;
        end else if (r >= 112 && r < 368) begin
          if (k < 32) h = 144 + 16 * k;
          else if (r == 367) h = 655;
        end else if (k == 0) begin
          h = 300;
        end
        if (h >= 0) begin
          drive(h, (r >= 370) ? 0 : r, (r < 370), 1'b0, 1'b0);
          if (h == 655) fin_idx = cnt;
          #1;
          if (scr_rd_en) begin
            reads++;
            last_addr = scr_addr;
            checks++;
            if (scr_addr !== 13'((r - 112) * 32 + k)) begin
              errors++; $display("FAIL frame_addr r=%0d k=%0d got %h want %h", r, k, scr_addr,
                                 13'((r - 112) * 32 + k));
            end
          end
          if (frame_done) begin
            pulses++;
            pulse_at = cnt;
          end
          cnt++;
        end
      end
    end
    checks++; if (reads != 8192) begin errors++; $display("FAIL frame_reads got %0d want 8192", reads); end
    checks++; if (last_addr !== 13'h1FFF) begin errors++; $display("FAIL frame_last_addr got %h want 1fff", last_addr); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL frame_done_count got %0d want 1", pulses); end
    checks++;
    if (pulse_at != fin_idx + 2) begin
      errors++; $display("FAIL frame_done_time got %0d want %0d", pulse_at, fin_idx + 2);
    end
  endtask

  task automatic test_reset_mid;
    int hj;
    mem[2832] = 16'hFFFF;
    mem[2833] = 16'h5555;
    for (int h = 390; h <= 400; h++) drive(h, 200, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (scr_rd_en !== 1'b1 || scr_addr !== 13'd2832) begin
      errors++; $display("FAIL mid_read got %b/%0d want 1/2832", scr_rd_en, scr_addr);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({rgb, de_o, hs_o, vs_o, frame_done, scr_rd_en, scr_addr} !== 34'h0) begin
      errors++; $display("FAIL mid_async_zero got rgb=%h de_o=%b rd=%b addr=%h want all 0",
                         rgb, de_o, scr_rd_en, scr_addr);
    end
    for (int h = 401; h <= 402; h++) begin
      drive(h, 200, 1'b1, 1'b0, 1'b0);
      #1;
      checks++;
      if (rgb !== 16'h0 || scr_rd_en !== 1'b0) begin
        errors++; $display("FAIL mid_held_zero got rgb=%h rd=%b want 0000/0", rgb, scr_rd_en);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (i < 23) drive(403 + i, 200, 1'b1, 1'b0, 1'b0);
      else drive(0, 0, 1'b0, 1'b0, 1'b0);
      #1;
      if (i == 13) begin
        checks++;
        if (scr_rd_en !== 1'b1 || scr_addr !== 13'd2833) begin
          errors++; $display("FAIL mid_resume_read got %b/%0d want 1/2833", scr_rd_en, scr_addr);
        end
      end
      hj = 403 + i - 2;
      if (i >= 2 && hj >= 416) begin
        checks++;
        if (rgb !== (((hj - 416) % 2 == 0) ? Fg : Bg)) begin
          errors++; $display("FAIL mid_resume_pixel h=%0d got %h want %h", hj, rgb,
                             (((hj - 416) % 2 == 0) ? Fg : Bg));
        end
      end
    end
  endtask

  task automatic test_border;
    int          h_s [11] = '{143, 656, 300, 300, 142, 657, 300, 300, 143, 0, 0};
    int          v_s [11] = '{200, 200, 111, 368, 200, 200, 110, 369, 200, 0, 0};
    logic [10:0] de_s = 11'b000_1111_1111;
    logic [15:0] e_s [9];
    e_s = '{Ring, Ring, Ring, Ring, Bg, Bg, Bg, Bg, 16'h0};
    for (int i = 0; i < 11; i++) begin
      drive(h_s[i], v_s[i], de_s[i], 1'b0, 1'b0);
      #1;
      if (i >= 2) begin
        checks++;
        if (rgb !== e_s[i-2]) begin
          errors++; $display("FAIL border_rgb (%0d,%0d) got %h want %h", h_s[i-2], v_s[i-2], rgb, e_s[i-2]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    de_i  = 1'b0;
    hs_i  = 1'b0;
    vs_i  = 1'b0;
    h_pos = '0;
    v_pos = '0;
    for (int a = 0; a < 8192; a++) mem[a] = 16'h0000;
    test_reset;
    test_single_word;
    test_row;
    test_outside;
    test_frame;
    test_reset_mid;
    test_border;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
